// File: rtl/traffic_intersection_ctrl_if.sv
// Lamp and request bundle between the intersection controller and whatever
// drives its inputs / observes its lamps.
interface traffic_intersection_ctrl_if;
   logic       ped_req;
   logic       night;
   logic       ns_g;
   logic       ns_y;
   logic       ns_r;
   logic       ew_g;
   logic       ew_y;
   logic       ew_r;
   logic       walk;
   logic [2:0] phase;

   modport master (
      output ped_req, night,
      input  ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, phase
   );

   modport slave (
      input  ped_req, night,
      output ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, phase
   );
endinterface

// File: rtl/traffic_intersection_ctrl.sv
// Two-approach intersection controller (north-south / east-west) clocked by
// the divided tick clock newClock. Green, yellow and all-red phases per
// direction, with a night-time flashing mode.
// Optional feature macro: PED_WALK_EN -- when defined, a latched pedestrian
// request stretches the next all-red by WALK_T ticks and lights walk.
//
// state    | meaning
// NS_GO    | north-south green, east-west red
// NS_WAIT  | north-south yellow, east-west red
// ALL_RED1 | both red (optionally with walk), then east-west
// EW_GO    | east-west green, north-south red
// EW_WAIT  | east-west yellow, north-south red
// ALL_RED2 | both red (optionally with walk), then north-south
// FLASH    | night mode: ns yellow and ew red blink together
module traffic_intersection_ctrl #(
   parameter int CNT_W    = 4,
   parameter int GREEN_T  = 6,
   parameter int YELLOW_T = 2,
   parameter int ALLRED_T = 1,
   parameter int WALK_T   = 3
) (
   input logic                       newClock,
   input logic                       rst,
   traffic_intersection_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      NS_GO    = 3'd0,
      NS_WAIT  = 3'd1,
      ALL_RED1 = 3'd2,
      EW_GO    = 3'd3,
      EW_WAIT  = 3'd4,
      ALL_RED2 = 3'd5,
      FLASH    = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] GREEN_TC  = CNT_W'(GREEN_T - 1);
   localparam logic [CNT_W-1:0] YELLOW_TC = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] ALLRED_TC = CNT_W'(ALLRED_T - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             blink, blink_nxt;
   logic             cnt_tc;
   logic             all_red;
   logic             ext;
   logic [6:0]       lamps;

`ifdef PED_WALK_EN
   localparam logic [CNT_W-1:0] ALLRED_EXT_TC = CNT_W'(ALLRED_T + WALK_T - 1);
   localparam logic [CNT_W-1:0] WALK_START    = CNT_W'(ALLRED_T);

   logic ped_pend, ped_pend_nxt, ext_nxt;
`else
   assign ext = 1'b0;
`endif

   assign all_red = (state == ALL_RED1) || (state == ALL_RED2);

   // terminal-count compare for the phase the FSM is currently in
   always_comb begin
      cnt_tc = 1'b0;
      case (state)
         NS_GO, EW_GO:       cnt_tc = (cnt == GREEN_TC);
         NS_WAIT, EW_WAIT:   cnt_tc = (cnt == YELLOW_TC);
`ifdef PED_WALK_EN
         ALL_RED1, ALL_RED2: cnt_tc = ext ? (cnt == ALLRED_EXT_TC) : (cnt == ALLRED_TC);
`else
         ALL_RED1, ALL_RED2: cnt_tc = (cnt == ALLRED_TC);
`endif
         default:            cnt_tc = 1'b0;
      endcase
   end

   // next state, phase counter, blink and pedestrian bookkeeping
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CNT_W'(1);
      blink_nxt = blink;
`ifdef PED_WALK_EN
      ext_nxt      = ext;
      ped_pend_nxt = ped_pend | bus.ped_req;
`endif
      case (state)
         NS_GO:    if (cnt_tc) state_nxt = NS_WAIT;
         NS_WAIT:  if (cnt_tc) state_nxt = ALL_RED1;
         ALL_RED1: if (cnt_tc) state_nxt = bus.night ? FLASH : EW_GO;
         EW_GO:    if (cnt_tc) state_nxt = EW_WAIT;
         EW_WAIT:  if (cnt_tc) state_nxt = ALL_RED2;
         ALL_RED2: if (cnt_tc) state_nxt = bus.night ? FLASH : NS_GO;
         FLASH: begin
            cnt_nxt   = '0;
            blink_nxt = ~blink;
            if (!bus.night) state_nxt = ALL_RED2;
         end
         default:  state_nxt = NS_GO;
      endcase
      if (cnt_tc) cnt_nxt = '0;
      if (state_nxt == FLASH && state != FLASH) blink_nxt = 1'b1;
`ifdef PED_WALK_EN
      // flash freezes the latch; leaving flash never grants a walk
      if (state == FLASH) begin
         ped_pend_nxt = ped_pend;
         ext_nxt      = 1'b0;
      end
      // a request arriving on the entry edge itself re-arms the latch
      if (cnt_tc && (state == NS_WAIT || state == EW_WAIT) && ped_pend) begin
         ext_nxt      = 1'b1;
         ped_pend_nxt = bus.ped_req;
      end
      if (cnt_tc && all_red) ext_nxt = 1'b0;
`endif
   end

   // state register and phase counter
   always_ff @(posedge newClock or negedge rst) begin
      if (!rst) begin
         state <= NS_GO;
         cnt   <= '0;
         blink <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         blink <= blink_nxt;
      end
   end

`ifdef PED_WALK_EN
   // pedestrian latch and all-red extension flag
   always_ff @(posedge newClock or negedge rst) begin
      if (!rst) begin
         ped_pend <= 1'b0;
         ext      <= 1'b0;
      end else begin
         ped_pend <= ped_pend_nxt;
         ext      <= ext_nxt;
      end
   end
`endif

   // Moore lamp decode: {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}
   always_comb begin
      lamps = 7'b0;
      case (state)
         NS_GO:              lamps[6:1] = 6'b100_001;
         NS_WAIT:            lamps[6:1] = 6'b010_001;
         ALL_RED1, ALL_RED2: lamps[6:1] = 6'b001_001;
         EW_GO:              lamps[6:1] = 6'b001_100;
         EW_WAIT:            lamps[6:1] = 6'b001_010;
         FLASH:              lamps[6:1] = {1'b0, blink, 3'b000, blink};
         default:            lamps[6:1] = 6'b100_001;
      endcase
`ifdef PED_WALK_EN
      lamps[0] = ext && all_red && (cnt >= WALK_START);
`else
      lamps[0] = ext;
`endif
   end

   assign bus.ns_g  = lamps[6];
   assign bus.ns_y  = lamps[5];
   assign bus.ns_r  = lamps[4];
   assign bus.ew_g  = lamps[3];
   assign bus.ew_y  = lamps[2];
   assign bus.ew_r  = lamps[1];
   assign bus.walk  = lamps[0];
   assign bus.phase = state;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Bench for traffic_intersection_ctrl with default parameters. Vectors are
// {ped_req, night, expected phase, expected lamps} per tick; tick 0 is the
// cycle that begins at reset release.
module tb_traffic_intersection_ctrl;

   logic newClock = 1'b0;
   logic rst      = 1'b0;

   traffic_intersection_ctrl_if bus ();

   traffic_intersection_ctrl dut (
      .newClock (newClock),
      .rst      (rst),
      .bus      (bus)
   );

   always #5 newClock = ~newClock;

   typedef struct {
      bit         ped_req;
      bit         night;
      logic [2:0] exp_phase;
      logic [6:0] exp_lamps;
   } vec_t;

   vec_t q[$];
   int   checks   = 0;
   int   failures = 0;

   // {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk}
   function automatic logic [6:0] lamps_for(input int ph, input bit b, input bit w);
      case (ph)
         0:       return 7'b1000010;
         1:       return 7'b0100010;
         2, 5:    return {6'b001001, w};
         3:       return 7'b0011000;
         4:       return 7'b0010100;
         6:       return {1'b0, b, 3'b000, b, 1'b0};
         default: return 7'b0;
      endcase
   endfunction

   task automatic add_phase(input int ph, input int n, input int ped_mask,
                            input bit nt, input int walk_from);
      for (int k = 0; k < n; k++) begin
         vec_t v;
         v.ped_req   = ped_mask[k];
         v.night     = nt;
         v.exp_phase = 3'(ph);
         v.exp_lamps = lamps_for(ph, 1'b0, (walk_from >= 0) && (k >= walk_from));
         q.push_back(v);
      end
   endtask

   task automatic add_flash(input int n, input int night_ticks);
      for (int k = 0; k < n; k++) begin
         vec_t v;
         v.ped_req   = 1'b0;
         v.night     = (k < night_ticks);
         v.exp_phase = 3'd6;
         v.exp_lamps = lamps_for(6, (k % 2) == 0, 1'b0);
         q.push_back(v);
      end
   endtask

   // one full cycle; x1/x2 mark an extended (4-tick, walk from tick 1) all-red
   task automatic add_cycle(input int m0, input int m1, input int m2, input int m3,
                            input int m4, input int m5, input bit x1, input bit x2,
                            input bit n3);
      add_phase(0, 6, m0, 1'b0, -1);
      add_phase(1, 2, m1, 1'b0, -1);
      add_phase(2, x1 ? 4 : 1, m2, 1'b0, x1 ? 1 : -1);
      add_phase(3, 6, m3, n3, -1);
      add_phase(4, 2, m4, 1'b0, -1);
      add_phase(5, x2 ? 4 : 1, m5, 1'b0, x2 ? 1 : -1);
   endtask

   task automatic check(input string name, input int idx,
                        input logic [2:0] exp_ph, input logic [6:0] exp_l);
      logic [6:0] act_l;
      act_l = {bus.ns_g, bus.ns_y, bus.ns_r, bus.ew_g, bus.ew_y, bus.ew_r, bus.walk};
      checks++;
      if (bus.phase !== exp_ph || act_l !== exp_l) begin
         failures++;
         $display("FAIL %s tick=%0d phase=%0d lamps=%b expected phase=%0d lamps=%b",
                  name, idx, bus.phase, act_l, exp_ph, exp_l);
      end
   endtask

   task automatic next_tick();
      @(posedge newClock);
      #2;
   endtask

   task automatic do_reset(input bit nt);
      rst         = 1'b0;
      bus.ped_req = 1'b0;
      bus.night   = nt;
      repeat (2) @(posedge newClock);
      #2;
      check("in_reset", 0, 3'd0, 7'b1000010);
      @(posedge newClock);
      #2;
      rst = 1'b1;
   endtask

   // applies the queued vectors starting at tick 0 of the current position
   task automatic run_vectors(input string name);
      for (int i = 0; i < q.size(); i++) begin
         if (i > 0) next_tick();
         bus.ped_req = q[i].ped_req;
         bus.night   = q[i].night;
         check(name, i, q[i].exp_phase, q[i].exp_lamps);
      end
      q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   initial begin
      bus.ped_req = 1'b0;
      bus.night   = 1'b0;

      // main run: several back-to-back cycles from reset
      do_reset(1'b0);
      add_cycle(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
`ifdef PED_WALK_EN
      add_cycle('b100, 0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
      add_cycle('b010, 'b10, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
      add_cycle(0, 'b10, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
`else
      add_cycle('b100, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      add_cycle(1, 1, 1, 1, 1, 1, 1'b0, 1'b0, 1'b0);
`endif
      add_cycle(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
      add_phase(0, 1, 0, 1'b0, -1);
      run_vectors("main");

      // night held from reset, flash, then drop night
      do_reset(1'b1);
      add_phase(0, 6, 0, 1'b1, -1);
      add_phase(1, 2, 0, 1'b1, -1);
      add_phase(2, 1, 0, 1'b1, -1);
      add_flash(5, 4);
      add_phase(5, 1, 0, 1'b0, -1);
      add_phase(0, 2, 0, 1'b0, -1);
      run_vectors("night");

      // asynchronous reset in EW_GO tick 11, then a full NS_GO
      do_reset(1'b0);
      add_phase(0, 6, 0, 1'b0, -1);
      add_phase(1, 2, 0, 1'b0, -1);
      add_phase(2, 1, 0, 1'b0, -1);
      add_phase(3, 3, 0, 1'b0, -1);
      run_vectors("pre_reset");
      #3;
      rst = 1'b0;
      #1;
      check("async_reset", 11, 3'd0, 7'b1000010);
      @(posedge newClock);
      #2;
      rst = 1'b1;
      add_phase(0, 6, 0, 1'b0, -1);
      add_phase(1, 1, 0, 1'b0, -1);
      run_vectors("post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/traffic_intersection_ctrl.md
# traffic_intersection_ctrl

Parametrised two-approach intersection controller (north-south / east-west) driven by the divided tick clock `newClock`. Sequences both directions through green, yellow and all-red phases with configurable durations per phase. Adds a latched pedestrian request that extends the all-red phase with a walk interval, and a night mode that flashes yellow/red. Sits downstream of the clock divider and drives the lamp outputs directly.

## Interface
Parameters:
- `CNT_W`, 4: phase counter width. Must hold max(GREEN_T, YELLOW_T, ALLRED_T+WALK_T)−1.
- `GREEN_T`, 6: green duration, in ticks (≥1).
- `YELLOW_T`, 2: yellow duration, in ticks (≥1).
- `ALLRED_T`, 1: base all-red duration, in ticks (≥1).
- `WALK_T`, 3: walk extension added to all-red, in ticks (≥1).

Ports:
- `newClock` in 1: tick clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `ped_req` in 1: pedestrian button, synchronous to `newClock`; a pulse of any length is latched.
- `night` in 1: night-mode request, synchronous level input.
- `ns_g`, `ns_y`, `ns_r` out 1 each: north-south lamps.
- `ew_g`, `ew_y`, `ew_r` out 1 each: east-west lamps.
- `walk` out 1: pedestrian walk lamp.
- `phase` out 3: current state code.

## Operation
- States and `phase` codes:
  - NS_GO=0: ns_g, ew_r.
  - NS_WAIT=1: ns_y, ew_r.
  - ALL_RED1=2: ns_r, ew_r.
  - EW_GO=3: ew_g, ns_r.
  - EW_WAIT=4: ew_y, ns_r.
  - ALL_RED2=5: ns_r, ew_r.
  - FLASH=6: see below.
- Normal order: NS_GO→NS_WAIT→ALL_RED1→EW_GO→EW_WAIT→ALL_RED2→NS_GO.
- Phase counter `cnt` is 0 on entry and increments each tick. A state of duration D exits on the edge where `cnt==D−1`; `cnt` then reloads to 0.
- Lamp outputs are Moore-decoded from the state register. In every state except FLASH, exactly one lamp per direction is lit.
- Pedestrian latch `ped_pend`:
  - Set on any edge where `ped_req`=1.
  - On the edge entering ALL_RED1 or ALL_RED2 with `ped_pend`=1: set `ext`←1, and `ped_pend`←`ped_req`. A request presented on that same edge therefore re-arms for the next all-red.
  - A request arriving on the entry edge itself, with `ped_pend`=0, is served at the next all-red.
- All-red duration is ALLRED_T, or ALLRED_T+WALK_T when `ext`=1.
  - `walk`=1 while `ext`=1, the state is all-red, and `cnt`≥ALLRED_T.
  - `ext` clears on all-red exit.
  - `walk` is never high in any other state.
- Night mode:
  - `night` is sampled only at the terminal edge of ALL_RED1/ALL_RED2. If it is 1, the next state is FLASH instead of the normal next state.
  - In FLASH, `blink` is set to 1 on entry and toggles every tick. ns_y=`blink`, ew_r=`blink`; all other lamps and `walk` are 0. `ped_pend` is held.
  - On any edge with `night`=0 in FLASH, go to ALL_RED2 with `cnt`=0 and `ext`=0, then on to NS_GO.
- `night` asserted mid-green or mid-yellow has no effect until the next all-red terminal edge. Lamps are never cut short.

## Timing
- Reset value of every output: ns_g=1, ew_r=1, all other lamps 0, `walk`=0, `phase`=0.
- Reset value of internal state: state NS_GO, `cnt`=0, `ped_pend`=0, `ext`=0, `blink`=0.
- Reset asserted mid-operation returns all outputs to their reset values immediately (asynchronously). The first full NS_GO starts at the first edge after release.
- Latency: a state change and its lamp change occur on the same `newClock` edge, with zero added cycles.
- Cycle period with default parameters:
  - No pedestrian request: 18 ticks.
  - One served request: 21 ticks.

## Configuration
- `PED_WALK_EN` defined: pedestrian latch, all-red extension and `walk` are implemented as described above.
- `PED_WALK_EN` undefined: `ped_req` is ignored, `walk` is tied to 0, and `ext`/`ped_pend` logic is removed. All-red is always ALLRED_T.

## Test plan
All scenarios use default parameters.
- Release reset, `ped_req`=0, `night`=0 → `phase` sequence 0×6, 1×2, 2×1, 3×6, 4×2, 5×1; `phase`=0 again at tick 18. Exactly one lamp per direction at every tick.
- Pulse `ped_req` for 1 tick during NS_GO tick 2 → ALL_RED1 lasts 4 ticks, `walk`=1 on its ticks 2–4. ALL_RED2 stays 1 tick with `walk`=0. `ped_pend`=0 afterwards.
- Hold `night`=1 from reset → FLASH entered after ALL_RED1, `phase`=6. ns_y sequence 1,0,1,0…; ew_r equals ns_y; all other lamps 0. Drop `night` → `phase`=5 for 1 tick, then `phase`=0.
- Assert `ped_req` on the exact edge entering ALL_RED1 while `ped_pend`=1 → current all-red is extended, and ALL_RED2 is also extended (request re-armed).
- Assert `rst`=0 mid EW_GO (tick 11) → outputs immediately ns_g=1, ew_r=1, `phase`=0. After release, NS_GO lasts a full 6 ticks.
- Build without `PED_WALK_EN` and pulse `ped_req` in every state → `walk` stays 0, period stays 18 ticks.
